// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line level and TX state encoding.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CPD_WIDTH = 10;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_DONE   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end_o on the last cycle of each bit period.
// A period of 0 behaves as 1, so bit_end_o is then high every cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int W = CPD_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear_i,
  input  logic [W-1:0] period_i,
  output logic         bit_end_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] last;

  // Last count value of a bit, with period 0 folded onto 1
  always_comb begin
    last = '0;
    if (period_i != '0) last = period_i - W'(1);
  end

  assign bit_end_o = (cnt_q == last);

  // Count up, wrapping at bit end or when cleared
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || bit_end_o) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 frames with a runtime bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = uart_pkg::DATA_BITS,
  parameter int CPD_WIDTH = uart_pkg::CPD_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CPD_WIDTH-1:0] cycles_per_databit,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CPD_WIDTH-1:0] period_q, period_d;
  logic                 line_q, line_d;
  logic                 bit_end;
  logic                 tmr_clear;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign tmr_clear = (state_q == TX_IDLE) || (state_q == TX_DONE);

  uart_bit_timer #(
    .W (CPD_WIDTH)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (tmr_clear),
    .period_i  (period_q),
    .bit_end_o (bit_end)
  );

  // Next-state, datapath and next line level
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    period_d = period_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          state_d  = TX_START;
          shift_d  = tx_data;
          period_d = cycles_per_databit;
`ifdef UART_TX_PARITY_EN
          par_d    = ^tx_data;
`endif
        end
      end
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (bit_end) state_d = TX_DONE;
      end
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    line_d = LINE_IDLE;
    unique case (state_d)
      TX_START: line_d = 1'b0;
      TX_DATA:  line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: line_d = par_q;
`endif
      default:  line_d = LINE_IDLE;
    endcase
  end

  // State and datapath registers; line is registered for a glitch-free pin
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= TX_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      period_q <= '0;
      line_q   <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      line_q   <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx_line  = line_q;
  assign tx_ready = (state_q == TX_IDLE);
  assign tx_done  = (state_q == TX_DONE);
  assign tx_busy  = !((state_q == TX_IDLE) || (state_q == TX_DONE));

endmodule
